// File: rtl/one_eight_32b_demux_reg_if.sv
// Bus interface for the 1:8 write-distribution bank.
// The master drives the write request (clr, in_valid, d, s, burst, len).
// The slave returns in_ready, the holding registers q0..q7, and the upd, busy and done status.
interface one_eight_32b_demux_reg_if #(
    parameter int unsigned N = 32
) ();
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] d;
    logic [2:0]   s;
    logic         burst;
    logic [2:0]   len;
    logic [N-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]   upd;
    logic         busy;
    logic         done;

    modport master (
        output clr, in_valid, d, s, burst, len,
        input  in_ready, q0, q1, q2, q3, q4, q5, q6, q7, upd, busy, done
    );

    modport slave (
        input  clr, in_valid, d, s, burst, len,
        output in_ready, q0, q1, q2, q3, q4, q5, q6, q7, upd, busy, done
    );
endinterface

// File: rtl/one_eight_32b_demux_reg.sv
// Registered 1:8 demultiplexer / write-distribution bank with auto-increment burst.
// Ports: clk, rst_n (async active-low) and bus (slave modport of the demux interface).
// Each accepted word lands in q[s], or in q[ptr] during a burst.
// upd is a one-hot strobe that marks the register whose new value is visible this cycle.
// done pulses for one cycle after the last burst word is written.
module one_eight_32b_demux_reg #(
    parameter int unsigned N = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    one_eight_32b_demux_reg_if.slave  bus
);
    localparam int unsigned NREG = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t       state;
    logic [2:0]   ptr;
    logic [2:0]   rem;
    logic [N-1:0] q_r [NREG];
    logic [7:0]   upd_r;
    logic         accept_c;

    // Ready is blocked only during the DONE cycle, while clr is high, or while in reset.
    assign bus.in_ready = rst_n & ~bus.clr & (state != ST_DONE);
    assign accept_c     = bus.in_valid & bus.in_ready;

    // Control FSM, holding registers and update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= 3'd0;
            rem   <= 3'd0;
            upd_r <= 8'd0;
            for (int i = 0; i < int'(NREG); i++) begin
                q_r[i] <= '0;
            end
        end else if (bus.clr) begin
            state <= ST_IDLE;
            rem   <= 3'd0;
            upd_r <= 8'd0;
            for (int i = 0; i < int'(NREG); i++) begin
                q_r[i] <= '0;
            end
        end else begin
            upd_r <= 8'd0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        q_r[bus.s] <= bus.d;
                        upd_r      <= 8'd1 << bus.s;
                        // len==0 is a single write, so it never enters BURST.
                        if (bus.burst && (bus.len != 3'd0)) begin
                            ptr   <= bus.s + 3'd1;
                            rem   <= bus.len;
                            state <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (accept_c) begin
                        q_r[ptr] <= bus.d;
                        upd_r    <= 8'd1 << ptr;
                        ptr      <= ptr + 3'd1;
                        rem      <= rem - 3'd1;
                        if (rem == 3'd1) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q0   = q_r[0];
    assign bus.q1   = q_r[1];
    assign bus.q2   = q_r[2];
    assign bus.q3   = q_r[3];
    assign bus.q4   = q_r[4];
    assign bus.q5   = q_r[5];
    assign bus.q6   = q_r[6];
    assign bus.q7   = q_r[7];
    assign bus.upd  = upd_r;
    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
endmodule

// File: tb/tb_one_eight_32b_demux_reg.sv
// Self-checking bench for the 1:8 demux bank.
// The driver keeps a destination-plan model and queues the expected upd strobes.
// A negedge monitor pops the queue and compares the registers, done and busy.
module tb_one_eight_32b_demux_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    one_eight_32b_demux_reg_if #(.N(32)) ifc ();

    one_eight_32b_demux_reg #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] exp_reg [8];
    int          plan [$];     // remaining burst destinations, in order
    logic [7:0]  scb [$];      // expected upd strobes
    bit          done_now = 0;
    bit          pending_done = 0;
    bit          busy_exp = 0;
    bit          wr_pending = 0;
    int          wr_idx = 0;
    logic [31:0] wr_val = '0;
    bit          started = 0;

    logic [31:0] qa [8];
    assign qa[0] = ifc.q0;
    assign qa[1] = ifc.q1;
    assign qa[2] = ifc.q2;
    assign qa[3] = ifc.q3;
    assign qa[4] = ifc.q4;
    assign qa[5] = ifc.q5;
    assign qa[6] = ifc.q6;
    assign qa[7] = ifc.q7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        plan.delete();
        scb.delete();
        for (int i = 0; i < 8; i++) exp_reg[i] = '0;
        done_now     = 0;
        pending_done = 0;
        busy_exp     = 0;
        wr_pending   = 0;
    endtask

    // Monitor: each negedge shows the result of the preceding rising edge.
    always @(negedge clk) begin
        if (rst_n && started) begin
            if (scb.size() > 0) begin
                logic [7:0] e;
                e = scb.pop_front();
                chk("upd", 32'(ifc.upd), 32'(e));
            end else begin
                chk("upd_quiet", 32'(ifc.upd), 32'd0);
            end
            for (int i = 0; i < 8; i++) chk($sformatf("q%0d", i), qa[i], exp_reg[i]);
            chk("done", 32'(ifc.done), 32'(done_now));
            chk("busy", 32'(ifc.busy), 32'(busy_exp));
        end
    end

    // One clock of stimulus. Inputs change just after the monitor has sampled.
    task automatic step(input bit v, input logic [31:0] dd, input logic [2:0] ss,
                        input bit b, input logic [2:0] l, input bit c);
        bit rdy;
        int dest;
        @(negedge clk);
        #1;
        ifc.in_valid = v;
        ifc.d        = dd;
        ifc.s        = ss;
        ifc.burst    = b;
        ifc.len      = l;
        ifc.clr      = c;
        #1;
        rdy = !c && !done_now;
        chk("in_ready", 32'(ifc.in_ready), 32'(rdy));
        if (c) begin
            plan.delete();
            for (int i = 0; i < 8; i++) exp_reg[i] = '0;
            pending_done = 0;
        end else if (v && rdy) begin
            if (plan.size() == 0) begin
                dest = int'(ss);
                if (b && l != 3'd0)
                    for (int k = 1; k <= int'(l); k++) plan.push_back((int'(ss) + k) % 8);
            end else begin
                dest = plan.pop_front();
                if (plan.size() == 0) pending_done = 1;
            end
            scb.push_back(8'd1 << dest);
            wr_pending = 1;
            wr_idx     = dest;
            wr_val     = dd;
        end
        @(posedge clk);
        #1;
        if (wr_pending) exp_reg[wr_idx] = wr_val;
        wr_pending   = 0;
        done_now     = pending_done;
        pending_done = 0;
        busy_exp     = (plan.size() > 0) || done_now;
    endtask

    initial begin
        ifc.in_valid = 0;
        ifc.d        = '0;
        ifc.s        = '0;
        ifc.burst    = 0;
        ifc.len      = '0;
        ifc.clr      = 0;
        model_clear();
        #2;
        // Reset values
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("rst_upd", 32'(ifc.upd), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_q%0d", i), qa[i], 32'd0);
        #11 rst_n = 1'b1;
        started = 1;

        // Single writes to each register
        for (int i = 0; i < 8; i++) step(1, 32'hA5A5_0000 + 32'(i), 3'(i), 0, 3'd0, 0);
        step(0, '0, 3'd0, 0, 3'd0, 0);

        // Full 8-word burst from 3 that wraps around
        for (int i = 0; i < 8; i++) step(1, 32'h10 + 32'(i), 3'd3, 1, 3'd7, 0);
        step(1, 32'hDEAD, 3'd1, 0, 3'd0, 0);   // DONE cycle: word must be refused
        step(0, '0, 3'd0, 0, 3'd0, 0);

        // Burst from 6 with gaps; s wiggles during the burst
        step(1, 32'h600, 3'd6, 1, 3'd2, 0);
        step(0, 32'h0, 3'd1, 0, 3'd0, 0);
        step(0, 32'h0, 3'd2, 0, 3'd0, 0);
        step(1, 32'h700, 3'd4, 1, 3'd5, 0);
        step(0, 32'h0, 3'd3, 0, 3'd0, 0);
        step(1, 32'h000, 3'd2, 0, 3'd0, 0);
        step(0, '0, 3'd0, 0, 3'd0, 0);
        step(0, '0, 3'd0, 0, 3'd0, 0);

        // clr on the second word of a burst
        step(1, 32'hC0, 3'd0, 1, 3'd4, 0);
        step(1, 32'hC1, 3'd0, 1, 3'd4, 1);
        step(1, 32'hC2, 3'd2, 0, 3'd0, 0);
        step(0, '0, 3'd0, 0, 3'd0, 0);

        // Asynchronous reset in the middle of a burst
        step(1, 32'hB0, 3'd1, 1, 3'd5, 0);
        step(1, 32'hB1, 3'd1, 1, 3'd5, 0);
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_upd", 32'(ifc.upd), 32'd0);
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_in_ready", 32'(ifc.in_ready), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("arst_q%0d", i), qa[i], 32'd0);
        #17 rst_n = 1'b1;
        step(1, 32'h5555, 3'd5, 0, 3'd0, 0);
        step(0, '0, 3'd0, 0, 3'd0, 0);

        // len=0 burst is a plain single write
        step(1, 32'h7777, 3'd7, 1, 3'd0, 0);
        step(0, '0, 3'd0, 0, 3'd0, 0);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 29) == 0));
        end
        step(0, '0, 3'd0, 0, 3'd0, 0);
        @(negedge clk);
        #2;
        if (scb.size() != 0) chk("scb_drain", 32'(scb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
